// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV64 control FSM: sequences fetch/decode/execute/mem/writeback and drives datapath controls.
// Latency: FETCH to next FETCH is 3 (beq), 4 (R/I, store) or 5 (load) cycles plus one per mem_ready-low cycle.
// Backpressure: mem_ready low stalls FETCH and MEM with the request held; it is ignored in all other states.

package control_signals;
    typedef enum logic [2:0] {
        OP_SUB = 3'b000,
        OP_AND = 3'b001,
        OP_OR  = 3'b011,
        OP_ADD = 3'b111
    } Alu_Operation_t;

    typedef enum logic {
        ALU_SRC_REG = 1'b0,
        ALU_SRC_IMM = 1'b1
    } Alu_Src_t;

    typedef enum logic {
        REG_SRC_MEM = 1'b0,
        REG_SRC_ALU = 1'b1
    } Reg_Data_Src_t;
endpackage

module multicycle_control_fsm
    import control_signals::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instr,
    input  logic                  mem_ready,
    output Alu_Operation_t        alu_op,
    output Alu_Src_t              alu_src,
    output Reg_Data_Src_t         reg_src,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  branch,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic                  illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        C_ALU,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_ILLEGAL
    } class_t;

    state_t         state, state_nxt;
    logic           run_en;

    class_t         dec_cls, lat_cls;
    Alu_Operation_t dec_op, lat_op;
    Alu_Src_t       dec_src, lat_src;
    Reg_Data_Src_t  dec_rsrc, lat_rsrc;

    logic [6:0]     opcode;
    logic [2:0]     f3;
    logic           f7b;
    logic           unused_instr_bits;

    assign opcode            = instr[6:0];
    assign f3                = instr[14:12];
    assign f7b               = instr[30];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    always_comb begin
        dec_cls  = C_ILLEGAL;
        dec_op   = OP_ADD;
        dec_src  = ALU_SRC_REG;
        dec_rsrc = REG_SRC_ALU;
        case (opcode)
            7'b0110011: begin
                case ({f7b, f3})
                    4'b0_000: begin dec_cls = C_ALU; dec_op = OP_ADD; end
                    4'b1_000: begin dec_cls = C_ALU; dec_op = OP_SUB; end
                    4'b0_111: begin dec_cls = C_ALU; dec_op = OP_AND; end
                    4'b0_110: begin dec_cls = C_ALU; dec_op = OP_OR;  end
                    default:  dec_cls = C_ILLEGAL;
                endcase
            end
            7'b0010011: begin
                dec_src = ALU_SRC_IMM;
                case (f3)
                    3'b000:  begin dec_cls = C_ALU; dec_op = OP_ADD; end
                    3'b111:  begin dec_cls = C_ALU; dec_op = OP_AND; end
                    3'b110:  begin dec_cls = C_ALU; dec_op = OP_OR;  end
                    default: dec_cls = C_ILLEGAL;
                endcase
            end
            7'b0000011: begin
                dec_src  = ALU_SRC_IMM;
                dec_rsrc = REG_SRC_MEM;
                if (f3 == 3'b010 || f3 == 3'b011) dec_cls = C_LOAD;
            end
            7'b0100011: begin
                dec_src = ALU_SRC_IMM;
                if (f3 == 3'b010 || f3 == 3'b011) dec_cls = C_STORE;
            end
            7'b1100011: begin
                dec_op = OP_SUB;
                if (f3 == 3'b000) dec_cls = C_BRANCH;
            end
            default: dec_cls = C_ILLEGAL;
        endcase
    end

    // run_en delays the first FETCH by one full cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            run_en <= 1'b0;
        end else begin
            state  <= state_nxt;
            run_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cls  <= C_ILLEGAL;
            lat_op   <= OP_ADD;
            lat_src  <= ALU_SRC_REG;
            lat_rsrc <= REG_SRC_ALU;
        end else if (state == S_DECODE) begin
            lat_cls  <= dec_cls;
            lat_op   <= dec_op;
            lat_src  <= dec_src;
            lat_rsrc <= dec_rsrc;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (run_en) state_nxt = S_FETCH;
            S_FETCH:     if (mem_ready) state_nxt = S_DECODE;
            S_DECODE:    state_nxt = (dec_cls == C_ILLEGAL) ? S_TRAP : S_EXECUTE;
            S_EXECUTE: begin
                case (lat_cls)
                    C_ALU:             state_nxt = S_WRITEBACK;
                    C_LOAD, C_STORE:   state_nxt = S_MEM;
                    C_BRANCH:          state_nxt = S_FETCH;
                    default:           state_nxt = S_TRAP;
                endcase
            end
            S_MEM:       if (mem_ready) state_nxt = (lat_cls == C_LOAD) ? S_WRITEBACK : S_FETCH;
            S_WRITEBACK: state_nxt = S_FETCH;
            S_TRAP:      state_nxt = S_TRAP;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        alu_op    = OP_ADD;
        alu_src   = ALU_SRC_REG;
        reg_src   = REG_SRC_ALU;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        branch    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        illegal   = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_EXECUTE: begin
                alu_op  = lat_op;
                alu_src = lat_src;
                branch  = (lat_cls == C_BRANCH);
            end
            S_MEM: begin
                mem_read  = (lat_cls == C_LOAD);
                mem_write = (lat_cls == C_STORE);
            end
            S_WRITEBACK: begin
                reg_write = 1'b1;
                reg_src   = lat_rsrc;
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle expected output words go into a scoreboard queue,
// and a negedge monitor pops one entry per cycle and compares it against the DUT outputs.
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ready;
    logic [2:0]  alu_op;
    logic        alu_src, reg_src;
    logic        ir_write, pc_write, branch, mem_read, mem_write, reg_write, illegal;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .mem_ready (mem_ready),
        .alu_op    (alu_op),
        .alu_src   (alu_src),
        .reg_src   (reg_src),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .branch    (branch),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .reg_write (reg_write),
        .illegal   (illegal)
    );

    // Word layout: {alu_op, alu_src, reg_src, ir_write, pc_write, branch, mem_read, mem_write, reg_write, illegal}
    localparam logic [11:0] V_IDLE   = {3'b111, 1'b0, 1'b1, 7'b0000000};
    localparam logic [11:0] V_FWAIT  = {3'b111, 1'b0, 1'b1, 7'b0001000};
    localparam logic [11:0] V_FDONE  = {3'b111, 1'b0, 1'b1, 7'b1101000};
    localparam logic [11:0] V_MRD    = {3'b111, 1'b0, 1'b1, 7'b0001000};
    localparam logic [11:0] V_MWR    = {3'b111, 1'b0, 1'b1, 7'b0000100};
    localparam logic [11:0] V_WB_ALU = {3'b111, 1'b0, 1'b1, 7'b0000010};
    localparam logic [11:0] V_WB_MEM = {3'b111, 1'b0, 1'b0, 7'b0000010};
    localparam logic [11:0] V_TRAP   = {3'b111, 1'b0, 1'b1, 7'b0000001};
    localparam logic [11:0] V_EX_SUB = {3'b000, 1'b0, 1'b1, 7'b0000000};
    localparam logic [11:0] V_EX_MEM = {3'b111, 1'b1, 1'b1, 7'b0000000};
    localparam logic [11:0] V_EX_BEQ = {3'b000, 1'b0, 1'b1, 7'b0010000};
    localparam logic [11:0] V_EX_AND = {3'b001, 1'b1, 1'b1, 7'b0000000};
    localparam logic [11:0] V_EX_OR  = {3'b011, 1'b1, 1'b1, 7'b0000000};

    typedef struct {
        logic [11:0] e;
        string       tag;
    } sb_item_t;

    sb_item_t    sb_q[$];
    sb_item_t    mon_item;
    logic        mon_en = 1'b0;
    int          n_cmp  = 0;
    int          n_bad  = 0;
    logic [11:0] got;

    assign got = {alu_op, alu_src, reg_src, ir_write, pc_write, branch,
                  mem_read, mem_write, reg_write, illegal};

    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_underflow: got=%b required=<queued entry>", got);
            end else begin
                mon_item = sb_q.pop_front();
                if (got !== mon_item.e) begin
                    n_bad++;
                    $display("FAIL %s: got=%b required=%b (t=%0t)", mon_item.tag, got, mon_item.e, $time);
                end
            end
        end
    end

    task automatic step(input logic rdy, input logic [11:0] e, input string tag);
        mem_ready = rdy;
        sb_q.push_back('{e: e, tag: tag});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ins, input int waits);
        instr = ins;
        for (int i = 0; i < waits; i++) step(1'b0, V_FWAIT, "fetch_wait");
        step(1'b1, V_FDONE, "fetch");
        step(1'b1, V_IDLE, "decode");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        instr     = 32'h0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset held with mem_ready high: nothing may assert.
        repeat (3) step(1'b1, V_IDLE, "in_reset");
        rst_n = 1'b1;
        step(1'b1, V_IDLE, "idle_after_release");
        step(1'b1, V_IDLE, "idle_edge1");

        // sub x3,x1,x2: FETCH on the 2nd edge, 4 cycles
        fetch(32'h402081B3, 0);
        step(1'b1, V_EX_SUB, "sub_exe");
        step(1'b1, V_WB_ALU, "sub_wb");

        // ld x5,8(x1) with two wait states in MEM: 7 cycles
        fetch(32'h0080B283, 0);
        step(1'b1, V_EX_MEM, "ld_exe");
        step(1'b0, V_MRD, "ld_mem_wait0");
        step(1'b0, V_MRD, "ld_mem_wait1");
        step(1'b1, V_MRD, "ld_mem_done");
        step(1'b1, V_WB_MEM, "ld_wb");

        // sd then beq back to back
        fetch(32'h0050B423, 0);
        step(1'b1, V_EX_MEM, "sd_exe");
        step(1'b1, V_MWR, "sd_mem");
        fetch(32'h00208463, 0);
        step(1'b1, V_EX_BEQ, "beq_exe");

        // andi with one fetch wait state, then ori
        fetch(32'h0FF0F093, 1);
        step(1'b1, V_EX_AND, "andi_exe");
        step(1'b1, V_WB_ALU, "andi_wb");
        fetch(32'h0010E093, 0);
        step(1'b1, V_EX_OR, "ori_exe");
        step(1'b1, V_WB_ALU, "ori_wb");

        // Illegal opcode: TRAP is sticky whatever mem_ready does
        fetch(32'h00000000, 0);
        for (int i = 0; i < 20; i++) step(i[0], V_TRAP, "trap_hold");

        // Asynchronous reset in the middle of a TRAP cycle
        mem_ready = 1'b1;
        sb_q.push_back('{e: V_IDLE, tag: "trap_rst_cycle"});
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (got !== V_IDLE) begin
            n_bad++;
            $display("FAIL trap_async_rst: got=%b required=%b", got, V_IDLE);
        end
        @(posedge clk);
        #1;
        step(1'b1, V_IDLE, "trap_rst_hold");
        rst_n = 1'b1;
        step(1'b1, V_IDLE, "idle_after_release2");
        step(1'b1, V_IDLE, "idle_edge1_2");
        fetch(32'h402081B3, 0);
        step(1'b1, V_EX_SUB, "sub2_exe");
        step(1'b1, V_WB_ALU, "sub2_wb");
        step(1'b0, V_FWAIT, "fetch_after_sub2");

        mon_en = 1'b0;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: got=%0d entries required=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
